soda_vend_ctrl: RTL and testbench

- Parametrised successor to the team's fixed-price soda FSM controller.
- Accepts 1/5/10-unit coins and accumulates credit up to a configurable PRICE.
- Pulses `bottle` when credit reaches PRICE, then pays change greedily: R5 pulses first, then R1 pulses, one coin per cycle.
- Adds a cancel/refund path, a `ready` flag and a visible credit value. Sits between the coin acceptor and the dispense/change actuators.

---
 rtl/soda_vend_ctrl_if.sv | 29 ++
 rtl/soda_vend_ctrl.sv | 145 ++++++++++++++
 tb/tb_soda_vend_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/soda_vend_ctrl_if.sv
`default_nettype none
// ============================================================================
// soda_vend_ctrl_if : coin/cancel inputs and dispense/change outputs bundle
// Revision: 1.0
// ============================================================================
interface soda_vend_ctrl_if #(
    parameter int CREDIT_W = 5
) ();
    logic                B1;
    logic                B5;
    logic                B10;
    logic                cancel;
    logic                ready;
    logic [CREDIT_W-1:0] credit;
    logic                bottle;
    logic                R1;
    logic                R5;

    modport master (
        output B1, B5, B10, cancel,
        input  ready, credit, bottle, R1, R5
    );

    modport slave (
        input  B1, B5, B10, cancel,
        output ready, credit, bottle, R1, R5
    );
endinterface
`default_nettype wire

// File: rtl/soda_vend_ctrl.sv
`default_nettype none
// ============================================================================
// soda_vend_ctrl : coin-credit vending FSM, greedy R5-then-R1 change return
// Revision: 1.0
// ============================================================================
module soda_vend_ctrl #(
    parameter int PRICE    = 3,
    parameter int CREDIT_W = 5
) (
    input  logic            clk,
    input  logic            reset_n,
    soda_vend_ctrl_if.slave bus
);

    localparam logic [1:0] S_COLLECT = 2'd0;
    localparam logic [1:0] S_VEND    = 2'd1;
    localparam logic [1:0] S_CHANGE  = 2'd2;

    localparam logic [CREDIT_W-1:0] C_PRICE = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] C_ZERO  = '0;
    localparam logic [CREDIT_W-1:0] C_ONE   = CREDIT_W'(1);
    localparam logic [CREDIT_W-1:0] C_FIVE  = CREDIT_W'(5);
    localparam logic [CREDIT_W-1:0] C_TEN   = CREDIT_W'(10);

    generate
        if (PRICE < 1 || PRICE > (2**CREDIT_W) - 11) begin : g_bad_price
            $error("soda_vend_ctrl: PRICE does not fit CREDIT_W");
        end
    endgenerate

    logic [1:0]          state_q,  state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W-1:0] change_q, change_d;
    logic                bottle_q, bottle_d;
    logic                r1_q,     r1_d;
    logic                r5_q,     r5_d;

    logic [CREDIT_W-1:0] coin_val;
    logic [CREDIT_W-1:0] sum;
    logic [CREDIT_W-1:0] pay_src;
    logic [CREDIT_W-1:0] pay_rem;
    logic                pay_r5;
    logic                pay_r1;

    // One coin per cycle, lowest denomination wins.
    always_comb begin
        coin_val = C_ZERO;
        if (bus.B1) begin
            coin_val = C_ONE;
        end else if (bus.B5) begin
            coin_val = C_FIVE;
        end else if (bus.B10) begin
            coin_val = C_TEN;
        end
    end

    assign sum = credit_q + coin_val;

    // Next change coin: a refund pays straight from the sum, otherwise from
    // the stored change. Remainder is what is still owed after this pulse.
    assign pay_src = (state_q == S_COLLECT) ? sum : change_q;
    assign pay_r5  = (pay_src >= C_FIVE);
    assign pay_r1  = !pay_r5 && (pay_src != C_ZERO);
    assign pay_rem = pay_r5 ? (pay_src - C_FIVE) :
                     pay_r1 ? (pay_src - C_ONE)  : pay_src;

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        change_d = change_q;
        bottle_d = 1'b0;
        r1_d     = 1'b0;
        r5_d     = 1'b0;
        case (state_q)
            S_COLLECT: begin
                if (bus.cancel && (sum != C_ZERO)) begin
                    state_d  = S_CHANGE;
                    credit_d = C_ZERO;
                    change_d = pay_rem;
                    r5_d     = pay_r5;
                    r1_d     = pay_r1;
                end else if (sum >= C_PRICE) begin
                    state_d  = S_VEND;
                    credit_d = C_ZERO;
                    change_d = sum - C_PRICE;
                    bottle_d = 1'b1;
                end else begin
                    credit_d = sum;
                end
            end
            S_VEND: begin
                credit_d = C_ZERO;
                if (change_q != C_ZERO) begin
                    state_d  = S_CHANGE;
                    change_d = pay_rem;
                    r5_d     = pay_r5;
                    r1_d     = pay_r1;
                end else begin
                    state_d  = S_COLLECT;
                end
            end
            S_CHANGE: begin
                credit_d = C_ZERO;
                if (change_q != C_ZERO) begin
                    change_d = pay_rem;
                    r5_d     = pay_r5;
                    r1_d     = pay_r1;
                end else begin
                    state_d  = S_COLLECT;
                end
            end
            default: begin
                state_d  = S_COLLECT;
                credit_d = C_ZERO;
                change_d = C_ZERO;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_COLLECT;
            credit_q <= C_ZERO;
            change_q <= C_ZERO;
            bottle_q <= 1'b0;
            r1_q     <= 1'b0;
            r5_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            change_q <= change_d;
            bottle_q <= bottle_d;
            r1_q     <= r1_d;
            r5_q     <= r5_d;
        end
    end

    assign bus.ready  = (state_q == S_COLLECT);
    assign bus.credit = credit_q;
    assign bus.bottle = bottle_q;
    assign bus.R1     = r1_q;
    assign bus.R5     = r5_q;

endmodule
`default_nettype wire

// File: tb/tb_soda_vend_ctrl.sv
`default_nettype none
// ============================================================================
// tb_soda_vend_ctrl : two controllers (PRICE 3 and 7) against a count model
// Revision: 1.0
// ============================================================================
module tb_soda_vend_ctrl;

    logic clk = 1'b0;
    logic reset_n;
    logic b1, b5, b10, cn;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    int PR[2] = '{3, 7};
    int m_cr[2];
    int m_bot[2];
    int m_n5[2];
    int m_n1[2];

    always #5 clk = ~clk;

    soda_vend_ctrl_if #(.CREDIT_W(5)) if0 ();
    soda_vend_ctrl_if #(.CREDIT_W(5)) if1 ();

    assign if0.B1 = b1;  assign if0.B5 = b5;  assign if0.B10 = b10;  assign if0.cancel = cn;
    assign if1.B1 = b1;  assign if1.B5 = b5;  assign if1.B10 = b10;  assign if1.cancel = cn;

    soda_vend_ctrl #(.PRICE(3), .CREDIT_W(5)) dut0 (.clk(clk), .reset_n(reset_n), .bus(if0.slave));
    soda_vend_ctrl #(.PRICE(7), .CREDIT_W(5)) dut1 (.clk(clk), .reset_n(reset_n), .bus(if1.slave));

    function automatic bit m_ready(input int k);
        return (m_bot[k] == 0) && (m_n5[k] == 0) && (m_n1[k] == 0);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cr[k] = 0; m_bot[k] = 0; m_n5[k] = 0; m_n1[k] = 0;
        end
    endtask

    // A vend or refund becomes a schedule: optional bottle, then c/5 R5 and c%5 R1.
    task automatic model_edge();
        int coin, sum, c;
        for (int k = 0; k < 2; k++) begin
            if (m_ready(k)) begin
                coin = b1 ? 1 : b5 ? 5 : b10 ? 10 : 0;
                sum  = m_cr[k] + coin;
                if (cn && sum > 0) begin
                    m_n5[k] = sum / 5; m_n1[k] = sum % 5; m_cr[k] = 0;
                end else if (sum >= PR[k]) begin
                    c = sum - PR[k];
                    m_bot[k] = 1; m_n5[k] = c / 5; m_n1[k] = c % 5; m_cr[k] = 0;
                end else begin
                    m_cr[k] = sum;
                end
            end else if (m_bot[k] != 0) begin
                m_bot[k] = 0;
            end else if (m_n5[k] != 0) begin
                m_n5[k]--;
            end else begin
                m_n1[k]--;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d: observed %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [31:0] e_bot, e_r5, e_r1, e_rdy;
        for (int k = 0; k < 2; k++) begin
            e_bot = (m_bot[k] != 0) ? 1 : 0;
            e_r5  = (m_bot[k] == 0 && m_n5[k] != 0) ? 1 : 0;
            e_r1  = (m_bot[k] == 0 && m_n5[k] == 0 && m_n1[k] != 0) ? 1 : 0;
            e_rdy = m_ready(k) ? 1 : 0;
            chk($sformatf("bottle%0d", k), 32'(k == 0 ? if0.bottle : if1.bottle), e_bot);
            chk($sformatf("R5_%0d", k),    32'(k == 0 ? if0.R5     : if1.R5),     e_r5);
            chk($sformatf("R1_%0d", k),    32'(k == 0 ? if0.R1     : if1.R1),     e_r1);
            chk($sformatf("ready%0d", k),  32'(k == 0 ? if0.ready  : if1.ready),  e_rdy);
            chk($sformatf("credit%0d", k), 32'(k == 0 ? if0.credit : if1.credit), 32'(m_cr[k]));
        end
    endtask

    task automatic cycle(input bit i1, input bit i5, input bit i10, input bit ic);
        @(negedge clk);
        b1 = i1; b5 = i5; b10 = i10; cn = ic;
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
    endtask

    // Drain any schedule, clear leftover credit with a refund, drain again.
    task automatic settle();
        idle(8);
        cycle(0, 0, 0, 1);
        idle(6);
    endtask

    initial begin
        reset_n = 1'b0;
        b1 = 0; b5 = 0; b10 = 0; cn = 0;
        model_reset();
        #2;
        check_all();
        @(negedge clk);
        reset_n = 1'b1;

        // Exact payment with 1-unit coins
        cycle(1, 0, 0, 0); cycle(1, 0, 0, 0); cycle(1, 0, 0, 0);
        settle();
        // 10 from zero: bottle then R5, R1, R1
        cycle(0, 0, 1, 0);
        settle();
        // 1 then 5: bottle then R1 x3
        cycle(1, 0, 0, 0); cycle(0, 1, 0, 0);
        settle();
        // Simultaneous B1+B10 counts as 1
        cycle(1, 0, 1, 0);
        settle();
        // Refund of partial credit, then cancel at zero credit
        cycle(1, 0, 0, 0); cycle(1, 0, 0, 0); cycle(0, 0, 0, 1);
        idle(4);
        cycle(0, 0, 0, 1);
        settle();
        // Coin during change phase is ignored
        cycle(0, 0, 1, 0); cycle(0, 0, 0, 0); cycle(0, 0, 1, 0);
        settle();
        // PRICE 7 cases: 5+5 -> three R1, 5+1+1 -> exact
        cycle(0, 1, 0, 0); cycle(0, 1, 0, 0);
        settle();
        cycle(0, 1, 0, 0); cycle(1, 0, 0, 0); cycle(1, 0, 0, 0);
        settle();

        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 12,
                  $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 6);
        end
        settle();

        // Asynchronous reset in the middle of change return
        cycle(0, 0, 1, 0);
        idle(2);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        reset_n = 1'b1;
        idle(3);
        cycle(1, 0, 0, 0);
        settle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
